// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode decode helpers and byte framing constants.
package spi_pkg;

    localparam int BYTE_W         = 8;
    localparam int BIT_CNT_W      = $clog2(BYTE_W + 1);
    localparam int EDGES_PER_BYTE = 16;
    localparam int EDGE_CNT_W     = $clog2(EDGES_PER_BYTE + 1);

    function automatic logic cpol(input int mode);
        return (mode == 2) || (mode == 3);
    endfunction

    function automatic logic cpha(input int mode);
        return (mode == 1) || (mode == 3);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: half-bit divider, edge counter, leading/trailing strobes
// and the registered SPI clock that idles at CPOL.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic edges_done,
    output logic lead_edge,
    output logic trail_edge,
    output logic spi_clk
);

    localparam logic CPOL  = cpol(SPI_MODE);
    localparam int   DIV_W = $clog2(2 * CLKS_PER_HALF_BIT);
    localparam logic [DIV_W-1:0] DIV_LEAD = DIV_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLKS_PER_HALF_BIT - 1);

    logic [EDGE_CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  sclk_int_q, sclk_int_d;
    logic                  sclk_out_q, sclk_out_d;
    logic                  lead_q, lead_d;
    logic                  trail_q, trail_d;

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        div_d      = div_q;
        sclk_int_d = sclk_int_q;
        sclk_out_d = sclk_int_q;
        lead_d     = 1'b0;
        trail_d    = 1'b0;
        if (start) begin
            // divider restarts from zero so back-to-back bytes keep exact bit timing
            edge_cnt_d = EDGE_CNT_W'(EDGES_PER_BYTE);
            div_d      = '0;
            sclk_int_d = CPOL;
        end else if (edge_cnt_q != '0) begin
            if (div_q == DIV_LAST) begin
                div_d      = '0;
                edge_cnt_d = edge_cnt_q - EDGE_CNT_W'(1);
                sclk_int_d = ~sclk_int_q;
                trail_d    = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
                if (div_q == DIV_LEAD) begin
                    edge_cnt_d = edge_cnt_q - EDGE_CNT_W'(1);
                    sclk_int_d = ~sclk_int_q;
                    lead_d     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
            div_q      <= '0;
            sclk_int_q <= CPOL;
            sclk_out_q <= CPOL;
            lead_q     <= 1'b0;
            trail_q    <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            div_q      <= div_d;
            sclk_int_q <= sclk_int_d;
            sclk_out_q <= sclk_out_d;
            lead_q     <= lead_d;
            trail_q    <= trail_d;
        end
    end

    assign edges_done = (edge_cnt_q == '0);
    assign lead_edge  = lead_q;
    assign trail_edge = trail_q;
    assign spi_clk    = sclk_out_q;

endmodule

// File: rtl/spi_byte_master.sv
// Single-byte full-duplex SPI master (modes 0-3); never drives chip-select.
// Define SPI_MASTER_LSB_FIRST_EN to shift bit 0 first on both TX and RX.
module spi_byte_master
    import spi_pkg::*;
#(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 8
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_SPI_Clk,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_MOSI
);

    localparam logic CPHA = cpha(SPI_MODE);
    localparam logic [BIT_CNT_W-1:0] BITS      = BIT_CNT_W'(BYTE_W);
    localparam logic [BIT_CNT_W-1:0] BITS_LAST = BIT_CNT_W'(BYTE_W - 1);

`ifdef SPI_MASTER_LSB_FIRST_EN
    function automatic logic first_bit(input logic [BYTE_W-1:0] b);
        return b[0];
    endfunction
    function automatic logic [BYTE_W-1:0] tx_shift(input logic [BYTE_W-1:0] b);
        return {1'b0, b[BYTE_W-1:1]};
    endfunction
    function automatic logic [BYTE_W-1:0] rx_insert(input logic [BYTE_W-1:0] b, input logic bit_in);
        return {bit_in, b[BYTE_W-1:1]};
    endfunction
`else
    function automatic logic first_bit(input logic [BYTE_W-1:0] b);
        return b[BYTE_W-1];
    endfunction
    function automatic logic [BYTE_W-1:0] tx_shift(input logic [BYTE_W-1:0] b);
        return {b[BYTE_W-2:0], 1'b0};
    endfunction
    function automatic logic [BYTE_W-1:0] rx_insert(input logic [BYTE_W-1:0] b, input logic bit_in);
        return {b[BYTE_W-2:0], bit_in};
    endfunction
`endif

    logic                 ready_q, ready_d;
    logic [BYTE_W-1:0]    tx_sr_q, tx_sr_d;
    logic [BIT_CNT_W-1:0] tx_left_q, tx_left_d;
    logic                 mosi_q, mosi_d;
    logic [BYTE_W-1:0]    rx_sr_q, rx_sr_d;
    logic [BIT_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [BYTE_W-1:0]    rx_byte_q, rx_byte_d;
    logic                 rx_dv_q, rx_dv_d;

    logic accept;
    logic edges_done;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic drive_edge;

    assign accept = i_TX_DV & ready_q;

    spi_clk_gen #(
        .SPI_MODE          (SPI_MODE),
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
    ) u_clk_gen (
        .clk        (i_Clk),
        .rst_n      (i_Rst_L),
        .start      (accept),
        .edges_done (edges_done),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .spi_clk    (o_SPI_Clk)
    );

    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign drive_edge  = CPHA ? lead_edge  : trail_edge;

    always_comb begin
        ready_d   = ~accept & edges_done;
        tx_sr_d   = tx_sr_q;
        tx_left_d = tx_left_q;
        mosi_d    = mosi_q;
        rx_sr_d   = rx_sr_q;
        rx_cnt_d  = rx_cnt_q;
        rx_byte_d = rx_byte_q;
        rx_dv_d   = 1'b0;
        if (accept) begin
            rx_cnt_d = '0;
            if (CPHA) begin
                tx_sr_d   = i_TX_Byte;
                tx_left_d = BITS;
            end else begin
                // CPHA=0 presents the first bit before any clock edge
                mosi_d    = first_bit(i_TX_Byte);
                tx_sr_d   = tx_shift(i_TX_Byte);
                tx_left_d = BITS_LAST;
            end
        end else begin
            if (drive_edge && tx_left_q != '0) begin
                mosi_d    = first_bit(tx_sr_q);
                tx_sr_d   = tx_shift(tx_sr_q);
                tx_left_d = tx_left_q - BIT_CNT_W'(1);
            end
            if (sample_edge && rx_cnt_q != BITS) begin
                rx_sr_d  = rx_insert(rx_sr_q, i_SPI_MISO);
                rx_cnt_d = rx_cnt_q + BIT_CNT_W'(1);
                if (rx_cnt_q == BITS_LAST) begin
                    rx_byte_d = rx_sr_d;
                    rx_dv_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            ready_q   <= 1'b1;
            tx_sr_q   <= '0;
            tx_left_q <= '0;
            mosi_q    <= 1'b0;
            rx_sr_q   <= '0;
            rx_cnt_q  <= '0;
            rx_byte_q <= '0;
            rx_dv_q   <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            tx_sr_q   <= tx_sr_d;
            tx_left_q <= tx_left_d;
            mosi_q    <= mosi_d;
            rx_sr_q   <= rx_sr_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_byte_q <= rx_byte_d;
            rx_dv_q   <= rx_dv_d;
        end
    end

    assign o_TX_Ready = ready_q;
    assign o_RX_DV    = rx_dv_q;
    assign o_RX_Byte  = rx_byte_q;
    assign o_SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: one instance per SPI mode, directed steps with a
// scoreboard of expected RX bytes and a cycle monitor of SCLK/MOSI behaviour.
module tb_spi_byte_master;

    localparam int H = 4;
    localparam int N = 4;

    typedef struct {
        int         inst;
        logic [7:0] b;
    } exp_t;

    logic gclk   = 1'b0;
    logic grst_n = 1'b1;

    logic [N-1:0]      tx_dv = '0;
    logic [N-1:0][7:0] tx_byte = '0;
    logic [N-1:0]      ready, rx_dv, sclk, miso, mosi;
    logic [N-1:0][7:0] rx_byte;

    always #5 gclk = ~gclk;

    for (genvar m = 0; m < N; m++) begin : g_dut
        spi_byte_master #(
            .SPI_MODE          (m),
            .CLKS_PER_HALF_BIT (H)
        ) u_dut (
            .i_Clk      (gclk),
            .i_Rst_L    (grst_n),
            .i_TX_Byte  (tx_byte[m]),
            .i_TX_DV    (tx_dv[m]),
            .o_TX_Ready (ready[m]),
            .o_RX_DV    (rx_dv[m]),
            .o_RX_Byte  (rx_byte[m]),
            .o_SPI_Clk  (sclk[m]),
            .i_SPI_MISO (miso[m]),
            .o_SPI_MOSI (mosi[m])
        );
    end

    // modes 0-2 loop MOSI back; mode 3 talks to a slave model returning 0xC3
    logic       s_miso = 1'b0;
    int         s_idx;
    logic [7:0] slv_byte = 8'hC3;
    assign miso[2:0] = mosi[2:0];
    assign miso[3]   = s_miso;

    function automatic logic cpol_of(input int i);
        return i >= 2;
    endfunction
    function automatic logic cpha_of(input int i);
        return (i % 2) == 1;
    endfunction

    // ---------------- monitor ----------------
    int           cyc;
    logic [N-1:0] sclk_p, mosi_p, ready_p;
    int           edge_cnt[N], rise_cnt[N], gap_ok[N], last_rise[N], low_cnt[N];
    int           mosi_lead[N], mosi_trail[N], rx_cnt[N], rise_ok[N], rise_late[N];
    bit           have_rise[N];
    logic         got_rx[N];
    logic [7:0]   sbits[N];
    logic [7:0]   rx_log[N][16];

    always @(negedge gclk) begin
        cyc     <= cyc + 1;
        sclk_p  <= sclk;
        mosi_p  <= mosi;
        ready_p <= ready;
        if (grst_n) begin
            for (int i = 0; i < N; i++) begin
                if (ready[i] === 1'b0) low_cnt[i] <= low_cnt[i] + 1;
                if (sclk[i] !== sclk_p[i]) begin
                    edge_cnt[i] <= edge_cnt[i] + 1;
                    if ((sclk[i] !== cpol_of(i)) ^ cpha_of(i))
                        sbits[i] <= {sbits[i][6:0], mosi[i]};
                    if (mosi[i] !== mosi_p[i]) begin
                        if (sclk[i] !== cpol_of(i)) mosi_lead[i] <= mosi_lead[i] + 1;
                        else                        mosi_trail[i] <= mosi_trail[i] + 1;
                    end
                    if (sclk[i] === 1'b1) begin
                        rise_cnt[i] <= rise_cnt[i] + 1;
                        if (have_rise[i] && (cyc - last_rise[i] == 2 * H)) gap_ok[i] <= gap_ok[i] + 1;
                        have_rise[i] <= 1'b1;
                        last_rise[i] <= cyc;
                    end
                end
                if (rx_dv[i] === 1'b1) begin
                    rx_log[i][rx_cnt[i][3:0]] <= rx_byte[i];
                    rx_cnt[i] <= rx_cnt[i] + 1;
                    got_rx[i] <= 1'b1;
                end
                if (ready[i] === 1'b0 && ready_p[i] === 1'b1) got_rx[i] <= 1'b0;
                if (ready[i] === 1'b1 && ready_p[i] === 1'b0) begin
                    if (got_rx[i] === 1'b1 || rx_dv[i] === 1'b1) rise_ok[i] <= rise_ok[i] + 1;
                    else                                         rise_late[i] <= rise_late[i] + 1;
                end
            end
            // slave drives on leading (falling, CPOL=1) edges of mode-3 SCLK
            if (ready[3] === 1'b1) s_idx <= 0;
            else if (sclk[3] !== sclk_p[3] && sclk[3] === 1'b0 && s_idx < 8) begin
                s_miso <= slv_byte[7 - s_idx];
                s_idx  <= s_idx + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   rd[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_tx(input int i, input logic [7:0] b);
        @(negedge gclk);
        tx_byte[i] = b;
        tx_dv[i]   = 1'b1;
        @(negedge gclk);
        tx_dv[i]   = 1'b0;
        chk("ready_low_after_accept", 32'(ready[i]), 32'd0);
    endtask

    task automatic send(input int i, input logic [7:0] b, input logic [7:0] exp_rx);
        exp_t e;
        e.inst = i;
        e.b    = exp_rx;
        exp_q.push_back(e);
        start_tx(i, b);
    endtask

    task automatic wait_ready(input int i);
        int k = 0;
        while (ready[i] !== 1'b1 && k < 1000) begin
            @(negedge gclk);
            k++;
        end
        chk("ready_timeout", 32'(ready[i]), 32'd1);
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_rx_seen"}, 32'(rx_cnt[e.inst] > rd[e.inst]), 32'd1);
            chk({tag, "_rx_byte"}, 32'(rx_log[e.inst][rd[e.inst][3:0]]), 32'(e.b));
            rd[e.inst]++;
        end
    endtask

    initial begin
        int b_rise, b_gap, b_low, b_lead, b_trail, b_ok, b_late, b_edge, k;

        #2 grst_n = 1'b0;
        repeat (3) @(negedge gclk);
        for (int i = 0; i < N; i++) begin
            chk("rst_ready", 32'(ready[i]), 32'd1);
            chk("rst_rx_dv", 32'(rx_dv[i]), 32'd0);
            chk("rst_rx_byte", 32'(rx_byte[i]), 32'd0);
            chk("rst_sclk", 32'(sclk[i]), 32'(cpol_of(i)));
            chk("rst_mosi", 32'(mosi[i]), 32'd0);
        end
        grst_n = 1'b1;
        repeat (2) @(negedge gclk);

        // mode 0 loopback 0xA5
        b_rise = rise_cnt[0]; b_gap = gap_ok[0]; b_low = low_cnt[0];
        send(0, 8'hA5, 8'hA5);
        wait_ready(0);
        repeat (3) @(negedge gclk);
        drain("m0");
        chk("m0_pulses", 32'(rx_cnt[0]), 32'(rd[0]));
        chk("m0_rises", 32'(rise_cnt[0] - b_rise), 32'd8);
        chk("m0_rise_spacing", 32'(gap_ok[0] - b_gap), 32'd7);
        chk("m0_ready_low", 32'(low_cnt[0] - b_low), 32'(16 * H + 1));
        chk("m0_mosi_bits", 32'(sbits[0]), 32'hA5);

        // mode 3 with slave returning 0xC3
        chk("m3_idle_before", 32'(sclk[3]), 32'd1);
        b_lead = mosi_lead[3]; b_trail = mosi_trail[3];
        send(3, 8'h3C, 8'hC3);
        wait_ready(3);
        repeat (3) @(negedge gclk);
        drain("m3");
        chk("m3_pulses", 32'(rx_cnt[3]), 32'(rd[3]));
        chk("m3_idle_after", 32'(sclk[3]), 32'd1);
        chk("m3_mosi_on_rise", 32'(mosi_trail[3] - b_trail), 32'd0);
        chk("m3_mosi_on_fall", 32'((mosi_lead[3] - b_lead) > 0), 32'd1);
        chk("m3_mosi_bits", 32'(sbits[3]), 32'h3C);

        // modes 1 and 2 with 0x81
        for (int i = 1; i <= 2; i++) begin
            b_lead = mosi_lead[i]; b_trail = mosi_trail[i];
            send(i, 8'h81, 8'h81);
            wait_ready(i);
            repeat (3) @(negedge gclk);
            drain("m12");
            chk("m12_pulses", 32'(rx_cnt[i]), 32'(rd[i]));
            chk("m12_mosi_bits", 32'(sbits[i]), 32'h81);
            chk("m12_wrong_drive_edge",
                32'(cpha_of(i) ? (mosi_trail[i] - b_trail) : (mosi_lead[i] - b_lead)), 32'd0);
        end

        // handshake: a second DV while busy is ignored
        b_low = low_cnt[0];
        send(0, 8'h69, 8'h69);
        repeat (10) @(negedge gclk);
        tx_byte[0] = 8'hFF;
        tx_dv[0]   = 1'b1;
        @(negedge gclk);
        tx_dv[0]   = 1'b0;
        chk("hs_still_busy", 32'(ready[0]), 32'd0);
        wait_ready(0);
        repeat (3) @(negedge gclk);
        drain("hs");
        chk("hs_pulses", 32'(rx_cnt[0]), 32'(rd[0]));
        chk("hs_mosi_bits", 32'(sbits[0]), 32'h69);
        chk("hs_ready_low", 32'(low_cnt[0] - b_low), 32'(16 * H + 1));

        // back-to-back 0x12 then 0x34 in the cycle ready returns
        b_ok = rise_ok[0]; b_late = rise_late[0];
        send(0, 8'h12, 8'h12);
        wait_ready(0);
        exp_q.push_back('{inst: 0, b: 8'h34});
        tx_byte[0] = 8'h34;
        tx_dv[0]   = 1'b1;
        @(negedge gclk);
        tx_dv[0]   = 1'b0;
        chk("b2b_accepted", 32'(ready[0]), 32'd0);
        wait_ready(0);
        repeat (3) @(negedge gclk);
        drain("b2b");
        chk("b2b_pulses", 32'(rx_cnt[0]), 32'(rd[0]));
        chk("b2b_rx_before_ready", 32'(rise_ok[0] - b_ok), 32'd2);
        chk("b2b_rx_late", 32'(rise_late[0] - b_late), 32'd0);

        // reset after 5 edges aborts the transfer
        b_edge = edge_cnt[0];
        start_tx(0, 8'hC7);
        k = 0;
        while (edge_cnt[0] - b_edge < 5 && k < 200) begin
            @(negedge gclk);
            k++;
        end
        chk("rst_mid_reached", 32'(edge_cnt[0] - b_edge >= 5), 32'd1);
        #1 grst_n = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(ready[0]), 32'd1);
        chk("rst_mid_rx_dv", 32'(rx_dv[0]), 32'd0);
        chk("rst_mid_rx_byte", 32'(rx_byte[0]), 32'd0);
        chk("rst_mid_sclk", 32'(sclk[0]), 32'd0);
        chk("rst_mid_mosi", 32'(mosi[0]), 32'd0);
        chk("rst_mid_sclk_m3", 32'(sclk[3]), 32'd1);
        @(negedge gclk);
        grst_n = 1'b1;
        repeat (2) @(negedge gclk);
        send(0, 8'h5A, 8'h5A);
        wait_ready(0);
        repeat (3) @(negedge gclk);
        drain("post_rst");
        chk("post_rst_pulses", 32'(rx_cnt[0]), 32'(rd[0]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

endmodule
